// File: rtl/flags_pkg.sv
// Shared constants and types for the flag register and its context stack.
// Bit indices name the default four-flag layout.
package flags_pkg;

  localparam int FLAG_WIDTH_DEF = 4;
  localparam int FLAG_DEPTH_DEF = 4;

  localparam int FLAG_Z = 0;
  localparam int FLAG_N = 1;
  localparam int FLAG_C = 2;
  localparam int FLAG_V = 3;

  // Resolved stack action for one cycle, after full/empty qualification
  typedef enum logic [2:0] {
    STK_IDLE = 3'd0,
    STK_PUSH = 3'd1,
    STK_POP  = 3'd2,
    STK_SWAP = 3'd3,
    STK_OVF  = 3'd4,
    STK_UNF  = 3'd5
  } stk_op_e;

endpackage

// File: rtl/flags_lifo.sv
// Context storage: DEPTH x WIDTH register array with one write port and one
// asynchronous read port. Contents are deliberately not reset.
module flags_lifo
  import flags_pkg::*;
#(
  parameter int WIDTH = FLAG_WIDTH_DEF,
  parameter int DEPTH = FLAG_DEPTH_DEF,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clock,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem_r [DEPTH];

  // Storage write; no reset so the array maps onto plain flops or LUT RAM
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem_r[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_r[rd_addr];

endmodule

// File: rtl/flags_stack.sv
// Architectural flag register with a saved-context LIFO. Pops restore flags,
// pushes save them, push+pop swaps; sticky bits record overflow/underflow.
module flags_stack
  import flags_pkg::*;
#(
  parameter int WIDTH = FLAG_WIDTH_DEF,
  parameter int DEPTH = FLAG_DEPTH_DEF
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         c14,
  input  logic [WIDTH-1:0]             flag_mask,
  input  logic [WIDTH-1:0]             flag_input,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         clear_err,
  output logic [WIDTH-1:0]             flag_reg,
  output logic [$clog2(DEPTH+1)-1:0]   depth_count,
  output logic                         full,
  output logic                         empty,
  output logic                         overflow,
  output logic                         underflow
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  stk_op_e          op_s;
  logic [AW-1:0]    top_idx_s;
  logic             wr_en_s;
  logic [AW-1:0]    wr_addr_s;
  logic [WIDTH-1:0] rd_data_s;
  logic [WIDTH-1:0] upd_flags_s;

  assign full        = (depth_count == CW'(DEPTH));
  assign empty       = (depth_count == CW'(0));
  assign top_idx_s   = AW'(depth_count - CW'(1));
  assign upd_flags_s = (flag_reg & ~flag_mask) | (flag_input & flag_mask);

  // Resolve push/pop request into a single stack action
  always_comb begin
    op_s = STK_IDLE;
    case ({push, pop})
      2'b10:   op_s = full  ? STK_OVF : STK_PUSH;
      2'b01:   op_s = empty ? STK_UNF : STK_POP;
      2'b11:   op_s = empty ? STK_UNF : STK_SWAP;
      default: op_s = STK_IDLE;
    endcase
  end

  // Storage write port: push writes above the top, swap overwrites the top
  always_comb begin
    wr_en_s   = 1'b0;
    wr_addr_s = AW'(depth_count);
    case (op_s)
      STK_PUSH: begin
        wr_en_s   = 1'b1;
        wr_addr_s = AW'(depth_count);
      end
      STK_SWAP: begin
        wr_en_s   = 1'b1;
        wr_addr_s = top_idx_s;
      end
      default: begin
        wr_en_s   = 1'b0;
        wr_addr_s = AW'(depth_count);
      end
    endcase
  end

  flags_lifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_lifo (
    .clock   (clock),
    .wr_en   (wr_en_s),
    .wr_addr (wr_addr_s),
    .wr_data (flag_reg),
    .rd_addr (top_idx_s),
    .rd_data (rd_data_s)
  );

  // Flag register: an effective pop (or swap) overrides the c14 update
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      flag_reg <= {WIDTH{1'b0}};
    end else if ((op_s == STK_POP) || (op_s == STK_SWAP)) begin
      flag_reg <= rd_data_s;
    end else if (c14) begin
      flag_reg <= upd_flags_s;
    end
  end

  // Saved-context count
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      depth_count <= CW'(0);
    end else begin
      case (op_s)
        STK_PUSH: depth_count <= depth_count + CW'(1);
        STK_POP:  depth_count <= depth_count - CW'(1);
        default:  depth_count <= depth_count;
      endcase
    end
  end

  // Sticky error bits; a same-cycle error event beats clear_err
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (op_s == STK_OVF) begin
        overflow <= 1'b1;
      end else if (clear_err) begin
        overflow <= 1'b0;
      end
      if (op_s == STK_UNF) begin
        underflow <= 1'b1;
      end else if (clear_err) begin
        underflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_flags_stack.sv
// Randomized and directed bench for flags_stack against a queue-based model
// of the flag register, context stack and sticky error bits.
module tb_flags_stack;

  localparam int WIDTH = 4;
  localparam int DEPTH = 4;

  logic       clock = 1'b0;
  logic       reset;
  logic       c14;
  logic [3:0] flag_mask;
  logic [3:0] flag_input;
  logic       push;
  logic       pop;
  logic       clear_err;
  logic [3:0] flag_reg;
  logic [2:0] depth_count;
  logic       full;
  logic       empty;
  logic       overflow;
  logic       underflow;

  int n_cmp = 0;
  int n_err = 0;

  logic [3:0] m_flag;
  logic [3:0] m_stk[$];
  bit         m_ovf;
  bit         m_unf;

  flags_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clock       (clock),
    .reset       (reset),
    .c14         (c14),
    .flag_mask   (flag_mask),
    .flag_input  (flag_input),
    .push        (push),
    .pop         (pop),
    .clear_err   (clear_err),
    .flag_reg    (flag_reg),
    .depth_count (depth_count),
    .full        (full),
    .empty       (empty),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_flag = 4'h0;
    m_stk.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  // Reference behaviour for one clock edge, written from the stack rules
  task automatic model_step(input bit pu, input bit po, input bit c, input logic [3:0] mk,
                            input logic [3:0] din, input bit clr);
    logic [3:0] upd;
    logic [3:0] t;
    bit ev_ovf, ev_unf;
    upd = (m_flag & ~mk) | (din & mk);
    ev_ovf = 1'b0;
    ev_unf = 1'b0;
    if (pu && po) begin
      if (m_stk.size() == 0) begin
        ev_unf = 1'b1;
        if (c) m_flag = upd;
      end else begin
        t = m_stk[m_stk.size()-1];
        m_stk[m_stk.size()-1] = m_flag;
        m_flag = t;
      end
    end else if (pu) begin
      if (m_stk.size() == DEPTH) ev_ovf = 1'b1;
      else m_stk.push_back(m_flag);
      if (c) m_flag = upd;
    end else if (po) begin
      if (m_stk.size() == 0) begin
        ev_unf = 1'b1;
        if (c) m_flag = upd;
      end else begin
        m_flag = m_stk.pop_back();
      end
    end else if (c) begin
      m_flag = upd;
    end
    if (clr) begin
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end
    if (ev_ovf) m_ovf = 1'b1;
    if (ev_unf) m_unf = 1'b1;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".flag_reg"},  32'(flag_reg),    32'(m_flag));
    chk({tag, ".depth"},     32'(depth_count), 32'(m_stk.size()));
    chk({tag, ".full"},      32'(full),        32'(m_stk.size() == DEPTH));
    chk({tag, ".empty"},     32'(empty),       32'(m_stk.size() == 0));
    chk({tag, ".overflow"},  32'(overflow),    32'(m_ovf));
    chk({tag, ".underflow"}, 32'(underflow),   32'(m_unf));
  endtask

  // Drive one cycle of inputs, clock it, update the model, compare #1 after the edge
  task automatic step(input string tag, input bit pu, input bit po, input bit c,
                      input logic [3:0] mk, input logic [3:0] din, input bit clr);
    push = pu; pop = po; c14 = c; flag_mask = mk; flag_input = din; clear_err = clr;
    @(posedge clock);
    model_step(pu, po, c, mk, din, clr);
    #1;
    check_all(tag);
  endtask

  // Asynchronous reset pulse between clock edges
  task automatic pulse_reset(input string tag);
    #2;
    reset = 1'b1;
    #1;
    chk({tag, ".rst_flag"},  32'(flag_reg),    32'h0);
    chk({tag, ".rst_depth"}, 32'(depth_count), 32'h0);
    chk({tag, ".rst_ovf"},   32'(overflow),    32'h0);
    chk({tag, ".rst_unf"},   32'(underflow),   32'h0);
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    reset = 1'b1;
    push = 1'b0; pop = 1'b0; c14 = 1'b0; clear_err = 1'b0;
    flag_mask = 4'h0; flag_input = 4'h0;
    model_reset();
    #1;
    chk("reset.flag_reg", 32'(flag_reg),    32'h0);
    chk("reset.depth",    32'(depth_count), 32'h0);
    chk("reset.empty",    32'(empty),       32'h1);
    chk("reset.full",     32'(full),        32'h0);
    @(posedge clock);
    #1;
    reset = 1'b0;

    // Masked update
    step("upd1", 1'b0, 1'b0, 1'b1, 4'hF, 4'b1010, 1'b0);
    chk("upd1.const", 32'(flag_reg), 32'(4'b1010));
    step("upd2", 1'b0, 1'b0, 1'b1, 4'b0001, 4'b0101, 1'b0);
    chk("upd2.const", 32'(flag_reg), 32'(4'b1011));
    step("hold", 1'b0, 1'b0, 1'b0, 4'hF, 4'b0000, 1'b0);

    // Push with concurrent update saves the pre-update value
    step("set3", 1'b0, 1'b0, 1'b1, 4'hF, 4'b0011, 1'b0);
    step("pushc", 1'b1, 1'b0, 1'b1, 4'hF, 4'b1100, 1'b0);
    chk("pushc.const", 32'(flag_reg), 32'(4'b1100));
    chk("pushc.depth1", 32'(depth_count), 32'd1);
    step("popr", 1'b0, 1'b1, 1'b1, 4'hF, 4'b1111, 1'b0);
    chk("popr.const", 32'(flag_reg), 32'(4'b0011));

    // Fill, overflow, drain in LIFO order, underflow
    for (int i = 0; i < 5; i++) step("fill", 1'b1, 1'b0, 1'b1, 4'hF, 4'(i + 5), 1'b0);
    chk("fill.full", 32'(full), 32'h1);
    chk("fill.ovf",  32'(overflow), 32'h1);
    for (int i = 0; i < 5; i++) step("drain", 1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 1'b0);
    chk("drain.unf", 32'(underflow), 32'h1);
    step("clr", 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b1);

    // Swap
    step("s_a", 1'b0, 1'b0, 1'b1, 4'hF, 4'b0110, 1'b0);
    step("s_b", 1'b1, 1'b0, 1'b1, 4'hF, 4'b1001, 1'b0);
    step("swap", 1'b1, 1'b1, 1'b1, 4'hF, 4'b1111, 1'b0);
    chk("swap.const", 32'(flag_reg), 32'(4'b0110));
    step("swpop", 1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 1'b0);
    chk("swpop.const", 32'(flag_reg), 32'(4'b1001));
    step("swemp", 1'b1, 1'b1, 1'b1, 4'hF, 4'b0101, 1'b0);

    // Reset mid-sequence discards contexts
    step("r_p1", 1'b1, 1'b0, 1'b1, 4'hF, 4'h7, 1'b0);
    step("r_p2", 1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0);
    pulse_reset("midrst");
    step("r_pop", 1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 1'b0);
    chk("r_pop.unf", 32'(underflow), 32'h1);
    step("r_clr", 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b1);
    chk("r_clr.unf", 32'(underflow), 32'h0);

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      int r;
      bit pu, po;
      r = $urandom_range(0, 7);
      pu = (r <= 2) || (r == 6);
      po = ((r >= 3) && (r <= 5)) || (r == 6);
      step("rand", pu, po, 1'($urandom_range(0, 1)), 4'($urandom), 4'($urandom),
           ($urandom_range(0, 7) == 0));
      if ($urandom_range(0, 79) == 0) pulse_reset("rrst");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
